// File: rtl/tl_rx_fc_pkg.sv
// Shared types and constants for the TL RX flow-control credit tracking path.
// FSM state encoding, data-credit unit sizes per counter width, and statistics width.
package tl_rx_fc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_ACCEPT = 2'd2,
        ST_DROP   = 2'd3
    } fc_state_e;

    // One data credit covers 4 DW at 12-bit width; scaled FC multiplies it by 4 per +2 bits.
    localparam int DATA_UNIT_DW_12 = 4;
    localparam int DATA_UNIT_DW_14 = 16;
    localparam int DATA_UNIT_DW_16 = 64;

    localparam int STAT_W = 16;

    function automatic int data_unit_shift(input int data_field_size);
        return 2 + (data_field_size - 12);
    endfunction

endpackage

// File: rtl/tl_rx_dw_to_data_credits.sv
// Combinational DW-to-data-credit conversion (ceiling division by the credit unit).
// A zero Length with payload means 2^PAYLOAD_LENGTH DW; no payload means zero credits.
module tl_rx_dw_to_data_credits
    import tl_rx_fc_pkg::*;
#(
    parameter int PAYLOAD_LENGTH  = 10,
    parameter int DATA_FIELD_SIZE = 12
) (
    input  logic [PAYLOAD_LENGTH-1:0]  len_dw_i,
    input  logic                       has_data_i,
    output logic [DATA_FIELD_SIZE-1:0] credits_o
);

    localparam int SHIFT = data_unit_shift(DATA_FIELD_SIZE);
    // Wide enough for 2^PAYLOAD_LENGTH plus the round-up term without overflow.
    localparam int SUM_W = PAYLOAD_LENGTH + SHIFT + 1;

    logic [SUM_W-1:0] len_full;
    logic [SUM_W-1:0] rounded;
    logic [SUM_W-1:0] quot;

    always_comb begin
        len_full = '0;
        if (has_data_i) begin
            if (len_dw_i == '0) len_full = SUM_W'(1) << PAYLOAD_LENGTH;
            else                len_full = SUM_W'(len_dw_i);
        end
        rounded   = len_full + SUM_W'((1 << SHIFT) - 1);
        quot      = rounded >> SHIFT;
        credits_o = DATA_FIELD_SIZE'(quot);
    end

endmodule

// File: rtl/tl_rx_credits_received_tracker.sv
// CREDITS_RECEIVED (hdr/data) tracker for one FC type: checks each TLP with the overflow checker, then commits or drops it.
// Optional TL_RX_OVERFLOW_STAT_EN adds a saturating ovf_drop_cnt output counting overflow verdicts.
module tl_rx_credits_received_tracker
    import tl_rx_fc_pkg::*;
#(
    parameter int PAYLOAD_LENGTH  = 10,
    parameter int HDR_FIELD_SIZE  = 8,
    parameter int DATA_FIELD_SIZE = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tlp_hdr_valid,
    input  logic                       tlp_has_data,
    input  logic [PAYLOAD_LENGTH-1:0]  tlp_length_dw,
    input  logic                       tlp_end,
    input  logic                       tlp_discard,
    input  logic                       receiver_overflow_error,
    output logic [HDR_FIELD_SIZE-1:0]  rcv_hdr,
    output logic [DATA_FIELD_SIZE-1:0] rcv_data,
    output logic [PAYLOAD_LENGTH-1:0]  buffer_in_dw,
    output logic                       receiver_overflow_en,
    output logic                       tlp_accept,
    output logic                       tlp_drop,
    output logic                       tlp_seq_err,
`ifdef TL_RX_OVERFLOW_STAT_EN
    output logic [STAT_W-1:0]          ovf_drop_cnt,
`endif
    output fc_state_e                  fsm_state_o
);

    fc_state_e                  state_q, state_d;
    logic [PAYLOAD_LENGTH-1:0]  len_q, len_d;
    logic                       has_data_q, has_data_d;
    logic [HDR_FIELD_SIZE-1:0]  rcv_hdr_q, rcv_hdr_d;
    logic [DATA_FIELD_SIZE-1:0] rcv_data_q, rcv_data_d;
    logic                       accept_q, accept_d;
    logic                       drop_q, drop_d;
    logic                       seq_err_q, seq_err_d;
    logic [DATA_FIELD_SIZE-1:0] tlp_credits;
    logic                       close_tlp;
    logic                       commit;

    tl_rx_dw_to_data_credits #(
        .PAYLOAD_LENGTH  (PAYLOAD_LENGTH),
        .DATA_FIELD_SIZE (DATA_FIELD_SIZE)
    ) u_dw_to_credits (
        .len_dw_i   (len_q),
        .has_data_i (has_data_q),
        .credits_o  (tlp_credits)
    );

    // Handshake: strobes are 1-cycle pulses; the checker verdict is only meaningful
    // while receiver_overflow_en is high and is sampled on the clock edge ending CHECK.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        has_data_d = has_data_q;
        rcv_hdr_d  = rcv_hdr_q;
        rcv_data_d = rcv_data_q;
        accept_d   = 1'b0;
        drop_d     = 1'b0;
        seq_err_d  = 1'b0;
        close_tlp  = 1'b0;
        commit     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tlp_hdr_valid) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (tlp_end) begin
                    close_tlp = 1'b1;
                    commit    = !receiver_overflow_error && !tlp_discard;
                end else begin
                    state_d = receiver_overflow_error ? ST_DROP : ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (tlp_end) begin
                    close_tlp = 1'b1;
                    commit    = !tlp_discard;
                end
            end
            ST_DROP: begin
                if (tlp_end) close_tlp = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (close_tlp) begin
            state_d  = ST_IDLE;
            accept_d = commit;
            drop_d   = !commit;
            if (commit) begin
                rcv_hdr_d  = rcv_hdr_q + HDR_FIELD_SIZE'(1);
                rcv_data_d = rcv_data_q + tlp_credits;
            end
        end

        // A header may open a new TLP only when none is open or the current one closes now.
        if (tlp_hdr_valid && (state_q == ST_IDLE || close_tlp)) begin
            state_d    = ST_CHECK;
            len_d      = tlp_has_data ? tlp_length_dw : '0;
            has_data_d = tlp_has_data;
        end else if (tlp_hdr_valid) begin
            seq_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            has_data_q <= 1'b0;
            rcv_hdr_q  <= '0;
            rcv_data_q <= '0;
            accept_q   <= 1'b0;
            drop_q     <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            has_data_q <= has_data_d;
            rcv_hdr_q  <= rcv_hdr_d;
            rcv_data_q <= rcv_data_d;
            accept_q   <= accept_d;
            drop_q     <= drop_d;
            seq_err_q  <= seq_err_d;
        end
    end

`ifdef TL_RX_OVERFLOW_STAT_EN
    logic [STAT_W-1:0] ovf_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else if (state_q == ST_CHECK && receiver_overflow_error && ovf_cnt_q != '1) begin
            ovf_cnt_q <= ovf_cnt_q + STAT_W'(1);
        end
    end

    assign ovf_drop_cnt = ovf_cnt_q;
`endif

    assign rcv_hdr              = rcv_hdr_q;
    assign rcv_data             = rcv_data_q;
    assign buffer_in_dw         = (state_q == ST_IDLE) ? '0 : len_q;
    assign receiver_overflow_en = (state_q == ST_CHECK);
    assign tlp_accept           = accept_q;
    assign tlp_drop             = drop_q;
    assign tlp_seq_err          = seq_err_q;
    assign fsm_state_o          = state_q;

endmodule

// File: tb/tb_tl_rx_credits_received_tracker.sv
// Directed self-checking bench for tl_rx_credits_received_tracker with default parameters.
// Build with TL_RX_OVERFLOW_STAT_EN defined to also check ovf_drop_cnt.
module tb_tl_rx_credits_received_tracker;
    import tl_rx_fc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        tlp_hdr_valid;
    logic        tlp_has_data;
    logic [9:0]  tlp_length_dw;
    logic        tlp_end;
    logic        tlp_discard;
    logic        receiver_overflow_error;
    logic [7:0]  rcv_hdr;
    logic [11:0] rcv_data;
    logic [9:0]  buffer_in_dw;
    logic        receiver_overflow_en;
    logic        tlp_accept;
    logic        tlp_drop;
    logic        tlp_seq_err;
`ifdef TL_RX_OVERFLOW_STAT_EN
    logic [15:0] ovf_drop_cnt;
`endif
    fc_state_e   fsm_state;

    int n_checks = 0;
    int n_pass   = 0;

    tl_rx_credits_received_tracker dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .tlp_hdr_valid           (tlp_hdr_valid),
        .tlp_has_data            (tlp_has_data),
        .tlp_length_dw           (tlp_length_dw),
        .tlp_end                 (tlp_end),
        .tlp_discard             (tlp_discard),
        .receiver_overflow_error (receiver_overflow_error),
        .rcv_hdr                 (rcv_hdr),
        .rcv_data                (rcv_data),
        .buffer_in_dw            (buffer_in_dw),
        .receiver_overflow_en    (receiver_overflow_en),
        .tlp_accept              (tlp_accept),
        .tlp_drop                (tlp_drop),
        .tlp_seq_err             (tlp_seq_err),
`ifdef TL_RX_OVERFLOW_STAT_EN
        .ovf_drop_cnt            (ovf_drop_cnt),
`endif
        .fsm_state_o             (fsm_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic hd, input logic [9:0] len);
        tlp_hdr_valid = 1'b1;
        tlp_has_data  = hd;
        tlp_length_dw = len;
        step();
        tlp_hdr_valid = 1'b0;
        tlp_has_data  = 1'b0;
        tlp_length_dw = '0;
    endtask

    task automatic check_cycle(input logic err);
        receiver_overflow_error = err;
        step();
        receiver_overflow_error = 1'b0;
    endtask

    task automatic end_tlp(input logic disc);
        tlp_end     = 1'b1;
        tlp_discard = disc;
        step();
        tlp_end     = 1'b0;
        tlp_discard = 1'b0;
    endtask

    task automatic run_tlp(input logic hd, input logic [9:0] len, input logic err, input logic disc);
        send_hdr(hd, len);
        check_cycle(err);
        end_tlp(disc);
    endtask

    task automatic check_counters(input string tag, input logic [7:0] hdr, input logic [11:0] data);
        check_eq({tag, "_hdr"}, 32'(rcv_hdr), 32'(hdr));
        check_eq({tag, "_data"}, 32'(rcv_data), 32'(data));
    endtask

    initial begin
        rst_n                   = 1'b0;
        tlp_hdr_valid           = 1'b0;
        tlp_has_data            = 1'b0;
        tlp_length_dw           = '0;
        tlp_end                 = 1'b0;
        tlp_discard             = 1'b0;
        receiver_overflow_error = 1'b0;
        step();
        step();

        // Reset state
        check_counters("rst", 8'd0, 12'd0);
        check_eq("rst_buf", 32'(buffer_in_dw), 32'd0);
        check_eq("rst_en", 32'(receiver_overflow_en), 32'd0);
        check_eq("rst_acc", 32'(tlp_accept), 32'd0);
        check_eq("rst_drop", 32'(tlp_drop), 32'd0);
        check_eq("rst_seq", 32'(tlp_seq_err), 32'd0);
        check_eq("rst_state", 32'(fsm_state), 32'(ST_IDLE));
`ifdef TL_RX_OVERFLOW_STAT_EN
        check_eq("rst_ovf", 32'(ovf_drop_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        step();

        // 1: MWr 16 DW, clean end -> 4 data credits
        send_hdr(1'b1, 10'd16);
        check_eq("t1_en", 32'(receiver_overflow_en), 32'd1);
        check_eq("t1_buf_check", 32'(buffer_in_dw), 32'd16);
        check_cycle(1'b0);
        check_eq("t1_state", 32'(fsm_state), 32'(ST_ACCEPT));
        check_eq("t1_en_off", 32'(receiver_overflow_en), 32'd0);
        check_eq("t1_buf_hold", 32'(buffer_in_dw), 32'd16);
        end_tlp(1'b0);
        check_counters("t1", 8'd1, 12'd4);
        check_eq("t1_acc", 32'(tlp_accept), 32'd1);
        check_eq("t1_drop", 32'(tlp_drop), 32'd0);
        check_eq("t1_buf_idle", 32'(buffer_in_dw), 32'd0);
        step();
        check_eq("t1_acc_pulse", 32'(tlp_accept), 32'd0);

        // 2: Length 0 = 1024 DW = 256 credits; climb to 12'hFFE, then wrap
        run_tlp(1'b1, 10'd0, 1'b0, 1'b0);
        check_counters("t2_len0", 8'd2, 12'd260);
        for (int i = 0; i < 14; i++) run_tlp(1'b1, 10'd0, 1'b0, 1'b0);
        run_tlp(1'b1, 10'd1000, 1'b0, 1'b0);
        check_counters("t2_pre", 8'd17, 12'hFFE);
        run_tlp(1'b1, 10'd12, 1'b0, 1'b0);
        check_counters("t2_wrap", 8'd18, 12'h001);

        // 3: overflow verdict -> drop
        send_hdr(1'b1, 10'd8);
        check_cycle(1'b1);
        check_eq("t3_state", 32'(fsm_state), 32'(ST_DROP));
        end_tlp(1'b0);
        check_counters("t3", 8'd18, 12'h001);
        check_eq("t3_drop", 32'(tlp_drop), 32'd1);
        check_eq("t3_acc", 32'(tlp_accept), 32'd0);
`ifdef TL_RX_OVERFLOW_STAT_EN
        check_eq("t3_ovf", 32'(ovf_drop_cnt), 32'd1);
`endif

        // 4: clean TLP discarded at end
        run_tlp(1'b1, 10'd32, 1'b0, 1'b1);
        check_counters("t4", 8'd18, 12'h001);
        check_eq("t4_drop", 32'(tlp_drop), 32'd1);
        check_eq("t4_acc", 32'(tlp_accept), 32'd0);

        // 5: header-only Msg with nonzero Length field, then another 1024-DW MWr
        send_hdr(1'b0, 10'd5);
        check_eq("t5_buf_msg", 32'(buffer_in_dw), 32'd0);
        check_cycle(1'b0);
        end_tlp(1'b0);
        check_counters("t5_msg", 8'd19, 12'h001);
        run_tlp(1'b1, 10'd0, 1'b0, 1'b0);
        check_counters("t5_len0", 8'd20, 12'd257);

        // 6a: back-to-back end + hdr_valid, then hdr_valid mid-TLP
        send_hdr(1'b1, 10'd8);
        check_cycle(1'b0);
        tlp_end       = 1'b1;
        tlp_hdr_valid = 1'b1;
        tlp_has_data  = 1'b1;
        tlp_length_dw = 10'd20;
        step();
        tlp_end       = 1'b0;
        tlp_hdr_valid = 1'b0;
        tlp_has_data  = 1'b0;
        tlp_length_dw = '0;
        check_counters("t6_b2b", 8'd21, 12'd259);
        check_eq("t6_b2b_acc", 32'(tlp_accept), 32'd1);
        check_eq("t6_b2b_state", 32'(fsm_state), 32'(ST_CHECK));
        check_eq("t6_b2b_buf", 32'(buffer_in_dw), 32'd20);
        check_cycle(1'b0);
        send_hdr(1'b1, 10'd4);
        check_eq("t6_seq", 32'(tlp_seq_err), 32'd1);
        check_eq("t6_seq_state", 32'(fsm_state), 32'(ST_ACCEPT));
        check_eq("t6_seq_buf", 32'(buffer_in_dw), 32'd20);
        step();
        check_eq("t6_seq_pulse", 32'(tlp_seq_err), 32'd0);
        end_tlp(1'b0);
        check_counters("t6_after_seq", 8'd22, 12'd264);

        // tlp_end during CHECK resolves immediately
        send_hdr(1'b1, 10'd4);
        end_tlp(1'b0);
        check_counters("t6_end_in_check", 8'd23, 12'd265);
        check_eq("t6_eic_state", 32'(fsm_state), 32'(ST_IDLE));
        check_eq("t6_eic_acc", 32'(tlp_accept), 32'd1);

        // tlp_end in IDLE is ignored
        step();
        end_tlp(1'b0);
        check_counters("t6_idle_end", 8'd23, 12'd265);
        check_eq("t6_idle_acc", 32'(tlp_accept), 32'd0);
        check_eq("t6_idle_drop", 32'(tlp_drop), 32'd0);

        // 6b: reset mid-ACCEPT abandons the TLP
        send_hdr(1'b1, 10'd4);
        check_cycle(1'b0);
        rst_n   = 1'b0;
        tlp_end = 1'b1;
        step();
        tlp_end = 1'b0;
        rst_n   = 1'b1;
        check_counters("t6_rst", 8'd0, 12'd0);
        check_eq("t6_rst_acc", 32'(tlp_accept), 32'd0);
        check_eq("t6_rst_drop", 32'(tlp_drop), 32'd0);
        check_eq("t6_rst_state", 32'(fsm_state), 32'(ST_IDLE));
        check_eq("t6_rst_buf", 32'(buffer_in_dw), 32'd0);
`ifdef TL_RX_OVERFLOW_STAT_EN
        check_eq("t6_rst_ovf", 32'(ovf_drop_cnt), 32'd0);
`endif
        step();
        check_eq("t6_post_acc", 32'(tlp_accept), 32'd0);
        check_eq("t6_post_drop", 32'(tlp_drop), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
